multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback.
- It produces the datapath strobes and muxes, and drives the 2-bit `aluop` code consumed by the ALU control decoder.
- It is the producer side of the `aluop` interface; the ALU control decoder maps `aluop` plus `func` to `aluc`.

---
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback.
// Optional memory handshake wait states are enabled with `define MULTICYCLE_CTRL_MEM_WAIT_EN.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [1:0]         aluop,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_SUB   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  state_t state_q;
  state_t state_d;
  state_t dec_state;
  logic   mem_ok;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  // The branch decision is made in the datapath (pc_write_cond & zero).
  logic unused_zero;
  assign unused_zero = zero;

  // Under reset the muxes show FETCH values regardless of where the state register is.
  assign dec_state = rst ? FETCH : state_q;
  assign state     = state_q;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred; blocking assignments are correct in combinational logic.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    aluop         = ALU_ADD;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (dec_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        aluop     = ALU_ADD;
        if (mem_ok) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        aluop     = ALU_ADD;
        case (opcode)
          OP_RTYPE:     state_d = R_EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = I_EXEC;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aluop     = ALU_ADD;
        state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ok) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = 1'b0;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ok) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        aluop     = ALU_RTYPE;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_B;
        aluop         = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aluop     = ALU_ADD;
        state_d   = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b0;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Abort without side effects: no strobe may fire while reset is held.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; covers the MULTICYCLE_CTRL_MEM_WAIT_EN build when defined.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  // Field order: pcw pcwc iord mrd mwr irw m2r rdst rwr asa | asb pcs aluop | done ill
  localparam ctl_t C_RESET    = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00, 1'b0,1'b0};
  localparam ctl_t C_FETCH    = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00, 1'b0,1'b0};
  localparam ctl_t C_DECODE   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b00,2'b00, 1'b0,1'b0};
  localparam ctl_t C_ILLEGAL  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b00,2'b00, 1'b1,1'b1};
  localparam ctl_t C_MEM_ADDR = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,2'b00, 1'b0,1'b0};
  localparam ctl_t C_MEM_RD   = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b0};
  localparam ctl_t C_MEM_WB   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00, 1'b1,1'b0};
  localparam ctl_t C_MEM_WR   = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b1,1'b0};
  localparam ctl_t C_R_EXEC   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b10, 1'b0,1'b0};
  localparam ctl_t C_R_WB     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00,2'b00,2'b00, 1'b1,1'b0};
  localparam ctl_t C_BRANCH   = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b01,2'b11, 1'b1,1'b0};
  localparam ctl_t C_JUMP     = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00, 1'b1,1'b0};
  localparam ctl_t C_I_EXEC   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,2'b00, 1'b0,1'b0};
  localparam ctl_t C_I_WB     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00, 1'b1,1'b0};
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  localparam ctl_t C_FETCH_WAIT  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00, 1'b0,1'b0};
  localparam ctl_t C_MEM_WR_WAIT = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b0};
`endif

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
                         S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
                         S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source, aluop;
  logic       instr_done, illegal_op;
  logic [3:0] st;
  ctl_t       obs;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .aluop(aluop), .instr_done(instr_done), .illegal_op(illegal_op), .state(st)
  );

  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                aluop, instr_done, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic expect_cycle(input string tag, input logic [3:0] exp_state, input ctl_t exp_ctl);
    check({tag, ".state"}, 32'(st), 32'(exp_state));
    check({tag, ".ctl"}, 32'(obs), 32'(exp_ctl));
  endtask

  // Inputs change only between the post-edge sample point and the next edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;

    // Reset held for two edges
    tick(); expect_cycle("rst1", S_FETCH, C_RESET);
    tick(); expect_cycle("rst2", S_FETCH, C_RESET);
    rst = 1'b0; #1;

    // R-type: 0,1,6,7,0
    expect_cycle("r.fetch", S_FETCH, C_FETCH);
    tick(); expect_cycle("r.decode", S_DECODE, C_DECODE);
    tick(); expect_cycle("r.exec", S_R_EXEC, C_R_EXEC);
    tick(); expect_cycle("r.wb", S_R_WB, C_R_WB);
    tick(); expect_cycle("r.end", S_FETCH, C_FETCH);

    // lw: 0,1,2,3,4,0
    opcode = 6'b100011; #1;
    tick(); expect_cycle("lw.decode", S_DECODE, C_DECODE);
    tick(); expect_cycle("lw.addr", S_MEM_ADDR, C_MEM_ADDR);
    tick(); expect_cycle("lw.rd", S_MEM_RD, C_MEM_RD);
    tick(); expect_cycle("lw.wb", S_MEM_WB, C_MEM_WB);
    tick(); expect_cycle("lw.end", S_FETCH, C_FETCH);

    // beq with zero toggled: controller output must not depend on it
    opcode = 6'b000100; zero = 1'b1; #1;
    tick(); expect_cycle("beq.decode", S_DECODE, C_DECODE);
    tick(); expect_cycle("beq.branch", S_BRANCH, C_BRANCH);
    zero = 1'b0; #1;
    expect_cycle("beq.branch_z0", S_BRANCH, C_BRANCH);
    tick(); expect_cycle("beq.end", S_FETCH, C_FETCH);

    // Illegal opcode: 2-cycle round trip
    opcode = 6'b111111; #1;
    tick(); expect_cycle("ill.decode", S_DECODE, C_ILLEGAL);
    tick(); expect_cycle("ill.end", S_FETCH, C_FETCH);

    // j
    opcode = 6'b000010; #1;
    tick(); expect_cycle("j.decode", S_DECODE, C_DECODE);
    tick(); expect_cycle("j.jump", S_JUMP, C_JUMP);
    tick(); expect_cycle("j.end", S_FETCH, C_FETCH);

    // addi
    opcode = 6'b001000; #1;
    tick(); expect_cycle("addi.decode", S_DECODE, C_DECODE);
    tick(); expect_cycle("addi.exec", S_I_EXEC, C_I_EXEC);
    tick(); expect_cycle("addi.wb", S_I_WB, C_I_WB);
    tick(); expect_cycle("addi.end", S_FETCH, C_FETCH);

`ifndef MULTICYCLE_CTRL_MEM_WAIT_EN
    // sw with mem_ready low: ignored in the single-cycle memory build
    opcode = 6'b101011; mem_ready = 1'b0; #1;
    expect_cycle("sw.fetch", S_FETCH, C_FETCH);
    tick(); expect_cycle("sw.decode", S_DECODE, C_DECODE);
    tick(); expect_cycle("sw.addr", S_MEM_ADDR, C_MEM_ADDR);
    tick(); expect_cycle("sw.wr", S_MEM_WR, C_MEM_WR);
    tick(); expect_cycle("sw.end", S_FETCH, C_FETCH);
    mem_ready = 1'b1;
`else
    // sw with wait states in FETCH and MEM_WR
    opcode = 6'b101011; mem_ready = 1'b0; #1;
    expect_cycle("swait.fetch_w0", S_FETCH, C_FETCH_WAIT);
    tick(); expect_cycle("swait.fetch_w1", S_FETCH, C_FETCH_WAIT);
    mem_ready = 1'b1; #1;
    expect_cycle("swait.fetch_go", S_FETCH, C_FETCH);
    tick(); expect_cycle("swait.decode", S_DECODE, C_DECODE);
    tick(); expect_cycle("swait.addr", S_MEM_ADDR, C_MEM_ADDR);
    mem_ready = 1'b0;
    tick(); expect_cycle("swait.wr_w0", S_MEM_WR, C_MEM_WR_WAIT);
    tick(); expect_cycle("swait.wr_w1", S_MEM_WR, C_MEM_WR_WAIT);
    tick(); expect_cycle("swait.wr_w2", S_MEM_WR, C_MEM_WR_WAIT);
    mem_ready = 1'b1; #1;
    expect_cycle("swait.wr_go", S_MEM_WR, C_MEM_WR);
    tick(); expect_cycle("swait.end", S_FETCH, C_FETCH);
`endif

    // sw aborted by reset in MEM_ADDR: no write ever issued
    opcode = 6'b101011; #1;
    tick(); expect_cycle("swa.decode", S_DECODE, C_DECODE);
    tick(); expect_cycle("swa.addr", S_MEM_ADDR, C_MEM_ADDR);
    rst = 1'b1; #1;
    expect_cycle("swa.rst_in_addr", S_MEM_ADDR, C_RESET);
    tick(); expect_cycle("swa.after_rst", S_FETCH, C_RESET);
    rst = 1'b0; #1;
    expect_cycle("swa.refetch", S_FETCH, C_FETCH);

    // R-type aborted in R_WB: register write suppressed while reset is high
    opcode = 6'b000000; #1;
    tick(); expect_cycle("ra.decode", S_DECODE, C_DECODE);
    tick(); expect_cycle("ra.exec", S_R_EXEC, C_R_EXEC);
    tick(); expect_cycle("ra.wb", S_R_WB, C_R_WB);
    rst = 1'b1; #1;
    expect_cycle("ra.rst_in_wb", S_R_WB, C_RESET);
    tick(); expect_cycle("ra.after_rst", S_FETCH, C_RESET);
    rst = 1'b0; #1;
    expect_cycle("ra.refetch", S_FETCH, C_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
